// File: rtl/ex_muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: IDLE -> PREP -> RUN (WIDTH steps) -> FIX.
// PREP takes operand magnitudes, RUN does one shift-add or restoring
// shift-subtract step per cycle, FIX restores signs and writes HI/LO.
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start_EX,
    input  logic [1:0]       Op_EX,
    input  logic [WIDTH-1:0] Operand_A_EX,
    input  logic [WIDTH-1:0] Operand_B_EX,
    input  logic             Write_HI_EX,
    input  logic             Write_LO_EX,
    input  logic [WIDTH-1:0] Move_Data_EX,
    output logic             Busy_EX,
    output logic             Done_EX,
    output logic             Div_By_Zero_EX,
    output logic [WIDTH-1:0] HI_EX,
    output logic [WIDTH-1:0] LO_EX
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam int             CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic               is_div;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand sign handling and the per-step arithmetic shared by RUN and FIX
    always_comb begin
        is_div    = op_q[1];
        sign_a    = op_q[0] & a_q[WIDTH-1];
        sign_b    = op_q[0] & b_q[WIDTH-1];
        abs_a     = sign_a ? (~a_q + 1'b1) : a_q;
        abs_b     = sign_b ? (~b_q + 1'b1) : b_q;
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mag_a_q} : '0);
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mag_b_q};
        div_ok    = ~div_diff[WIDTH+1];
        prod_raw  = {work_hi_q, work_lo_q};
        prod_fix  = neg_res_q ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix   = neg_res_q ? (~work_lo_q + 1'b1) : work_lo_q;
        rem_fix   = neg_rem_q ? (~work_hi_q + 1'b1) : work_hi_q;
    end

    // Next-state logic for the sequencer, datapath and architectural HI/LO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start_EX) begin
                    state_d = S_PREP;
                    op_d    = Op_EX;
                    a_d     = Operand_A_EX;
                    b_d     = Operand_B_EX;
                end else begin
                    if (Write_HI_EX) hi_d = Move_Data_EX;
                    if (Write_LO_EX) lo_d = Move_Data_EX;
                end
            end
            S_PREP: begin
                // Multiply shifts the multiplier through work_lo; divide shifts the dividend
                mag_a_d   = abs_a;
                mag_b_d   = abs_b;
                work_hi_d = '0;
                work_lo_d = is_div ? abs_a : abs_b;
                neg_res_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                cnt_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    if (div_ok) begin
                        work_hi_d = div_diff[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi_d = div_shift[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    work_hi_d = mul_sum[WIDTH:1];
                    work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div) begin
                    if (b_q == '0) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign Busy_EX        = (state_q != S_IDLE);
    assign Done_EX        = done_q;
    assign Div_By_Zero_EX = dbz_q;
    assign HI_EX          = hi_q;
    assign LO_EX          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Randomized self-checking bench for ex_muldiv_sequencer against an arithmetic model.
module tb_ex_muldiv_sequencer;

    localparam int W = 32;

    logic         Clk;
    logic         Reset;
    logic         Start_EX;
    logic [1:0]   Op_EX;
    logic [W-1:0] Operand_A_EX;
    logic [W-1:0] Operand_B_EX;
    logic         Write_HI_EX;
    logic         Write_LO_EX;
    logic [W-1:0] Move_Data_EX;
    logic         Busy_EX;
    logic         Done_EX;
    logic         Div_By_Zero_EX;
    logic [W-1:0] HI_EX;
    logic [W-1:0] LO_EX;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_hi  = '0;
    logic [W-1:0] exp_lo  = '0;

    ex_muldiv_sequencer #(.WIDTH(W)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start_EX       (Start_EX),
        .Op_EX          (Op_EX),
        .Operand_A_EX   (Operand_A_EX),
        .Operand_B_EX   (Operand_B_EX),
        .Write_HI_EX    (Write_HI_EX),
        .Write_LO_EX    (Write_LO_EX),
        .Move_Data_EX   (Move_Data_EX),
        .Busy_EX        (Busy_EX),
        .Done_EX        (Done_EX),
        .Div_By_Zero_EX (Div_By_Zero_EX),
        .HI_EX          (HI_EX),
        .LO_EX          (LO_EX)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        dz = 1'b0;
        sa = (op[0]) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (op[0]) ? longint'($signed(b)) : longint'({32'b0, b});
        if (!op[1]) begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Issue one operation in the current cycle and check every cycle through Done.
    // disturb: extra Start at cycle 4 and MTHI at cycle 6, both to be ignored.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        logic [W-1:0] e_hi, e_lo;
        logic         e_dz;
        model(op, a, b, e_hi, e_lo, e_dz);
        Start_EX     = 1'b1;
        Op_EX        = op;
        Operand_A_EX = a;
        Operand_B_EX = b;
        tick();
        Start_EX     = 1'b0;
        Write_HI_EX  = 1'b0;
        Write_LO_EX  = 1'b0;
        Op_EX        = 2'($urandom);
        Operand_A_EX = $urandom;
        Operand_B_EX = $urandom;
        for (int cyc = 1; cyc <= W + 3; cyc++) begin
            check_eq("busy", Busy_EX, (cyc <= W + 2));
            check_eq("done", Done_EX, (cyc == W + 3));
            check_eq("dbz", Div_By_Zero_EX, (cyc == W + 3) && e_dz);
            if (cyc == W + 3) begin
                check_eq("hi", HI_EX, e_hi);
                check_eq("lo", LO_EX, e_lo);
                exp_hi = e_hi;
                exp_lo = e_lo;
            end else begin
                if (cyc < W + 3 && cyc != 1) begin
                    check_eq("hi_hold", HI_EX, exp_hi);
                    check_eq("lo_hold", LO_EX, exp_lo);
                end
                if (disturb && cyc == 4) begin
                    Start_EX = 1'b1; Op_EX = 2'b10; Operand_A_EX = 9; Operand_B_EX = 3;
                end
                if (disturb && cyc == 6) begin
                    Write_HI_EX = 1'b1; Move_Data_EX = 32'h1234;
                end
                tick();
                Start_EX    = 1'b0;
                Write_HI_EX = 1'b0;
                Write_LO_EX = 1'b0;
            end
        end
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        bit           seen_done;

        Reset = 1'b1; Start_EX = 1'b0; Op_EX = '0; Operand_A_EX = '0; Operand_B_EX = '0;
        Write_HI_EX = 1'b0; Write_LO_EX = 1'b0; Move_Data_EX = '0;
        tick(); tick();
        Reset = 1'b0;
        check_eq("rst_busy", Busy_EX, 0);
        check_eq("rst_done", Done_EX, 0);
        check_eq("rst_dbz", Div_By_Zero_EX, 0);
        check_eq("rst_hi", HI_EX, 0);
        check_eq("rst_lo", LO_EX, 0);

        // Reset wins over Start and moves in the same cycle
        Reset = 1'b1; Start_EX = 1'b1; Write_HI_EX = 1'b1; Write_LO_EX = 1'b1; Move_Data_EX = 32'h55;
        tick();
        Reset = 1'b0; Start_EX = 1'b0; Write_HI_EX = 1'b0; Write_LO_EX = 1'b0;
        check_eq("rstpri_busy", Busy_EX, 0);
        check_eq("rstpri_hi", HI_EX, 0);
        check_eq("rstpri_lo", LO_EX, 0);
        tick();
        check_eq("rstpri_busy2", Busy_EX, 0);

        // Directed cases
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check_eq("multu_max_hi", HI_EX, 32'hFFFFFFFE);
        check_eq("multu_max_lo", LO_EX, 32'h00000001);
        run_op(2'b01, 32'hFFFFFFFD, 32'd7, 0);
        check_eq("mult_neg_lo", LO_EX, 32'hFFFFFFEB);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
        check_eq("div_neg_lo", LO_EX, 32'hFFFFFFFD);
        check_eq("div_neg_hi", HI_EX, 32'hFFFFFFFF);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
        check_eq("div_ovf_lo", LO_EX, 32'h80000000);
        check_eq("div_ovf_hi", HI_EX, 32'h0);
        run_op(2'b10, 32'd100, 32'd0, 0);
        check_eq("divz_hi", HI_EX, 32'h64);
        run_op(2'b11, 32'hFFFFFF00, 32'd0, 0);
        run_op(2'b00, 32'd5, 32'd6, 1);
        check_eq("dist_hi", HI_EX, 0);
        check_eq("dist_lo", LO_EX, 30);

        // Moves in IDLE
        tick();
        Write_LO_EX = 1'b1; Move_Data_EX = 32'hABCD;
        tick();
        Write_LO_EX = 1'b0;
        exp_lo = 32'hABCD;
        check_eq("mtlo_lo", LO_EX, exp_lo);
        check_eq("mtlo_hi", HI_EX, exp_hi);
        Write_HI_EX = 1'b1; Write_LO_EX = 1'b1; Move_Data_EX = 32'h13579BDF;
        tick();
        Write_HI_EX = 1'b0; Write_LO_EX = 1'b0;
        exp_hi = 32'h13579BDF; exp_lo = 32'h13579BDF;
        check_eq("mtboth_hi", HI_EX, exp_hi);
        check_eq("mtboth_lo", LO_EX, exp_lo);

        // Start coinciding with a move: the operation must be accepted
        Write_HI_EX = 1'b1; Move_Data_EX = 32'hDEAD;
        run_op(2'b10, 32'd1000, 32'd7, 0);

        // Reset mid-operation
        Start_EX = 1'b1; Op_EX = 2'b00; Operand_A_EX = 32'd77; Operand_B_EX = 32'd88;
        tick();
        Start_EX = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check_eq("abort_busy", Busy_EX, 0);
        check_eq("abort_hi", HI_EX, 0);
        check_eq("abort_lo", LO_EX, 0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done_EX || Div_By_Zero_EX || Busy_EX) seen_done = 1;
            tick();
        end
        check_eq("abort_quiet", seen_done, 0);
        run_op(2'b01, 32'd12345, 32'hFFFFFFFE, 0);

        // Randomized back-to-back operations
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom % 8)
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin ra = 32'($urandom % 64); rb = 32'($urandom % 16); end
                3: rb = 32'hFFFFFFF0 | 32'($urandom % 16);
                default: ;
            endcase
            run_op(rop, ra, rb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
